// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} lsu_state_e;

    localparam logic [15:0] LSU_LAST_ADDR = 16'hFFFF;
    localparam int          LSU_BYTE_W    = 8;
endpackage

// File: rtl/lsu_if.sv
// Request/response handshake plus data_memory bus for the load/store unit.
interface lsu_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_byte;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport lsu (
        input  req_valid, req_we, req_byte, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_re, mem_we, mem_addr, mem_wdata
    );

    modport tb (
        output req_valid, req_we, req_byte, req_signed, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_re, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_byte_lane.sv
// Low-byte extraction with sign/zero extension, and byte-store merge into the
// high byte read back from memory.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [2*LSU_BYTE_W-1:0] rdata,
    input  logic [LSU_BYTE_W-1:0]   wbyte,
    input  logic                    sgn,
    output logic [2*LSU_BYTE_W-1:0] ext,
    output logic [2*LSU_BYTE_W-1:0] merged
);
    assign ext    = {{LSU_BYTE_W{sgn & rdata[LSU_BYTE_W-1]}}, rdata[LSU_BYTE_W-1:0]};
    assign merged = {rdata[2*LSU_BYTE_W-1:LSU_BYTE_W], wbyte};
endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one request at a time, byte stores done as read-modify-write.
// Optional macro LSU_ALIGN_CHECK_EN rejects word accesses at odd addresses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic clk,
    input  logic reset,
    lsu_if.lsu   bus,
    output logic busy
);
    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic              byte_q, byte_d;
    logic              sgn_q, sgn_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              acc_err;
    logic [DATA_W-1:0] ext_rdata;
    logic [DATA_W-1:0] merged_wdata;

    lsu_byte_lane u_lane (
        .rdata  (bus.mem_rdata),
        .wbyte  (wdata_q[LSU_BYTE_W-1:0]),
        .sgn    (sgn_q),
        .ext    (ext_rdata),
        .merged (merged_wdata)
    );

    // Word accesses need addr+1; at the last address that byte does not exist.
    always_comb begin
        acc_err = !bus.req_byte && (bus.req_addr == ADDR_W'(LSU_LAST_ADDR));
`ifdef LSU_ALIGN_CHECK_EN
        if (!bus.req_byte && bus.req_addr[0]) acc_err = 1'b1;
`endif
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        byte_d  = byte_q;
        sgn_d   = sgn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                we_d    = bus.req_we;
                byte_d  = bus.req_byte;
                sgn_d   = bus.req_signed;
                addr_d  = bus.req_addr;
                wdata_d = bus.req_wdata;
                rdata_d = '0;
                err_d   = acc_err;
                if (acc_err)                          state_d = RESP;
                else if (bus.req_we && !bus.req_byte) state_d = WR;
                else                                  state_d = RD;
            end
            RD:  state_d = CAP;
            // Byte store: the merged word replaces the latched store data.
            CAP: if (we_q) begin
                wdata_d = merged_wdata;
                state_d = WR;
            end else begin
                rdata_d = byte_q ? ext_rdata : bus.mem_rdata;
                state_d = RESP;
            end
            WR:   state_d = RESP;
            RESP: if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.mem_re     = (state_q == RD);
    assign bus.mem_we     = (state_q == WR);
    assign bus.mem_addr   = (state_q == RD || state_q == WR) ? addr_q : '0;
    assign bus.mem_wdata  = (state_q == WR) ? wdata_q : '0;
    assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed data_memory model.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic mem_init;
    int   checks = 0;
    int   errors = 0;
    int   re_cnt = 0;
    int   we_cnt = 0;
    logic both_seen = 1'b0;
    logic [7:0]  mem [0:65535];
    logic [15:0] mem_rdata_r;

    lsu_if bus ();

    load_store_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.lsu),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem_rdata_r;

    // data_memory model: reads {mem[a+1], mem[a]} registered, writes both bytes.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
            mem[0] <= 8'hCD;
            mem[1] <= 8'h2B;
            mem_rdata_r <= 16'h0000;
        end else begin
            if (bus.mem_re)
                mem_rdata_r <= {(bus.mem_addr == 16'hFFFF) ? 8'h00 : mem[bus.mem_addr + 16'd1],
                                mem[bus.mem_addr]};
            if (bus.mem_we) begin
                mem[bus.mem_addr] <= bus.mem_wdata[7:0];
                if (bus.mem_addr != 16'hFFFF) mem[bus.mem_addr + 16'd1] <= bus.mem_wdata[15:8];
            end
        end
        if (bus.mem_re) re_cnt <= re_cnt + 1;
        if (bus.mem_we) we_cnt <= we_cnt + 1;
        if (bus.mem_re && bus.mem_we) both_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic byt, input logic sgn,
                          input logic [15:0] addr, input logic [15:0] wdata, input int hold,
                          output logic [15:0] rd, output logic er, output int lat);
        logic done;
        logic stable;
        @(negedge clk);
        bus.req_we     = we;
        bus.req_byte   = byt;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        lat  = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            lat++;
            if (bus.resp_valid) done = 1'b1;
        end
        chk("resp_seen", {31'd0, done}, 32'd1);
        rd = bus.resp_rdata;
        er = bus.resp_err;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bus.resp_valid || bus.resp_rdata !== rd || bus.resp_err !== er || bus.req_ready)
                stable = 1'b0;
        end
        if (hold > 0) chk("hold_stable", {31'd0, stable}, 32'd1);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("resp_drop", {31'd0, bus.resp_valid}, 32'd0);
        chk("req_ready_after", {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic        er;
        int          lat;
        int          re0, we0;

        reset = 1'b1; mem_init = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_byte = 1'b0;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; mem_init = 1'b0;

        chk("rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
        chk("rst_busy",       {31'd0, busy},           32'd0);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_mem_re",     {31'd0, bus.mem_re},     32'd0);
        chk("rst_mem_we",     {31'd0, bus.mem_we},     32'd0);
        chk("rst_mem_addr",   {16'd0, bus.mem_addr},   32'd0);
        chk("rst_mem_wdata",  {16'd0, bus.mem_wdata},  32'd0);
        chk("rst_resp_rdata", {16'd0, bus.resp_rdata}, 32'd0);
        chk("rst_resp_err",   {31'd0, bus.resp_err},   32'd0);

        // Word and byte loads from the reset image
        do_req(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, rd, er, lat);
        chk("wld0_data", {16'd0, rd}, 32'h2BCD);
        chk("wld0_err",  {31'd0, er}, 32'd0);
        chk("wld0_lat",  lat, 32'd3);
        do_req(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 0, rd, er, lat);
        chk("bld0_s", {16'd0, rd}, 32'hFFCD);
        do_req(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, rd, er, lat);
        chk("bld0_u", {16'd0, rd}, 32'h00CD);
        do_req(1'b0, 1'b1, 1'b1, 16'h0001, 16'h0000, 0, rd, er, lat);
        chk("bld1_s", {16'd0, rd}, 32'h002B);

        // Byte store via read-modify-write
        re0 = re_cnt; we0 = we_cnt;
        do_req(1'b1, 1'b1, 1'b0, 16'h0000, 16'hAA5A, 0, rd, er, lat);
        chk("bst_lat",   lat, 32'd4);
        chk("bst_rdata", {16'd0, rd}, 32'h0000);
        chk("bst_err",   {31'd0, er}, 32'd0);
        chk("bst_re",    re_cnt - re0, 32'd1);
        chk("bst_we",    we_cnt - we0, 32'd1);
        do_req(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, rd, er, lat);
        chk("bst_readback", {16'd0, rd}, 32'h2B5A);

        // Word store with backpressure
        do_req(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 5, rd, er, lat);
        chk("wst_lat",   lat, 32'd2);
        chk("wst_rdata", {16'd0, rd}, 32'h0000);
        chk("wst_err",   {31'd0, er}, 32'd0);
        do_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 0, rd, er, lat);
        chk("wst_readback", {16'd0, rd}, 32'hBEEF);

        // Last-address boundary
        re0 = re_cnt; we0 = we_cnt;
        do_req(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 0, rd, er, lat);
        chk("wFFFF_err",   {31'd0, er}, 32'd1);
        chk("wFFFF_lat",   lat, 32'd1);
        chk("wFFFF_rdata", {16'd0, rd}, 32'h0000);
        chk("wFFFF_re",    re_cnt - re0, 32'd0);
        chk("wFFFF_we",    we_cnt - we0, 32'd0);
        re0 = re_cnt;
        do_req(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 0, rd, er, lat);
        chk("bFFFF_err", {31'd0, er}, 32'd0);
        chk("bFFFF_lat", lat, 32'd3);
        chk("bFFFF_re",  re_cnt - re0, 32'd1);

        // Odd word address
        we0 = we_cnt;
        do_req(1'b1, 1'b0, 1'b0, 16'h0003, 16'hDEAD, 0, rd, er, lat);
`ifdef LSU_ALIGN_CHECK_EN
        chk("odd_err", {31'd0, er}, 32'd1);
        chk("odd_lat", lat, 32'd1);
        chk("odd_we",  we_cnt - we0, 32'd0);
        do_req(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, 0, rd, er, lat);
        chk("odd_mem", {16'd0, rd}, 32'h0000);
`else
        chk("odd_err", {31'd0, er}, 32'd0);
        chk("odd_lat", lat, 32'd2);
        chk("odd_we",  we_cnt - we0, 32'd1);
        do_req(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 0, rd, er, lat);
        chk("odd_mem", {16'd0, rd}, 32'hDEAD);
`endif

        // Reset during the CAP state of a byte store
        do_req(1'b1, 1'b0, 1'b0, 16'h0020, 16'h1234, 0, rd, er, lat);
        re0 = re_cnt; we0 = we_cnt;
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_byte = 1'b1; bus.req_signed = 1'b0;
        bus.req_addr = 16'h0020; bus.req_wdata = 16'h0077; bus.req_valid = 1'b1;
        @(negedge clk);                 // RD
        bus.req_valid = 1'b0;
        @(negedge clk);                 // CAP
        chk("abort_busy", {31'd0, busy}, 32'd1);
        chk("abort_re",   re_cnt - re0, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_req_ready",  {31'd0, bus.req_ready},  32'd1);
        chk("abort_busy_clr",   {31'd0, busy},           32'd0);
        chk("abort_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        repeat (4) @(negedge clk);
        chk("abort_no_we", we_cnt - we0, 32'd0);
        do_req(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 0, rd, er, lat);
        chk("abort_mem", {16'd0, rd}, 32'h1234);

        chk("re_we_exclusive", {31'd0, both_seen}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage sitting directly upstream of data_memory. It accepts one load/store request at a time from the execute stage over a valid/ready handshake and drives data_memory's read_enable/write_enable/addr/data_in. It captures data_out and returns an extended result, or a store completion, over a second valid/ready handshake. Byte stores are performed as read-modify-write, because data_memory always writes both bytes of a word.

Parameters:
ADDR_W, 16, address width; matches data_memory addr.
DATA_W, 16, data width; fixed at 16 (two 8-bit lanes).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_byte  in  1  1 = byte access, 0 = word access
req_signed  in  1  byte load: 1 = sign-extend, 0 = zero-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data (byte store uses [7:0])
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  DATA_W  load result; 0 for stores
resp_err  out  1  access rejected, no memory write performed
mem_re  out  1  to data_memory read_enable
mem_we  out  1  to data_memory write_enable
mem_addr  out  ADDR_W  to data_memory addr
mem_wdata  out  DATA_W  to data_memory data_in
mem_rdata  in  DATA_W  from data_memory data_out (valid the cycle after mem_re)
busy  out  1  state != IDLE

Behaviour:
- Synchronous, active-high reset on the clk edge. State goes to IDLE; latched request, resp_rdata and resp_err are cleared to 0. After reset: resp_valid=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, req_ready=1, busy=0.
- Reset mid-operation aborts the operation. No further mem_we is issued, even if the abort falls between the read and the write of a byte store.
- mem_re and mem_we are decoded from the state and are never both high.
- States:
  - IDLE: req_ready=1. On req_valid, latch all request fields.
    - Error case (see below): go to RESP with resp_err=1.
    - Word store: go to WR.
    - Load or byte store: go to RD.
  - RD: mem_re=1, mem_addr=latched addr. Go to CAP.
  - CAP: sample mem_rdata.
    - Word load: resp_rdata=mem_rdata.
    - Byte load: resp_rdata={8{sign}, mem_rdata[7:0]} if req_signed, else {8'h00, mem_rdata[7:0]}; sign = mem_rdata[7].
    - Byte store: merged={mem_rdata[15:8], wdata[7:0]}; go to WR.
    - Loads go to RESP.
  - WR: mem_we=1, mem_addr=latched addr, mem_wdata=wdata (word store) or merged (byte store). Go to RESP.
  - RESP: resp_valid=1, outputs held stable until resp_ready. On resp_ready, go to IDLE; resp_valid drops the next cycle.
- A new request is not accepted in the same cycle as a response handshake; req_ready rises the cycle after.
- Latency from the accept edge to resp_valid: word store 2 cycles, load 3 cycles, byte store 4 cycles, error 1 cycle.
- Boundary: a word access at addr 0xFFFF (addr+1 out of range) always gives resp_err=1, with no mem_re and no mem_we. A byte access at 0xFFFF is legal.
- Stores return resp_rdata=0.

Optional Feature:
LSU_ALIGN_CHECK_EN:
- Defined: any word access with addr[0]=1 is rejected as an error (1-cycle response, resp_err=1, no memory access).
- Undefined: odd word addresses proceed normally; only the 0xFFFF rule raises an error.

Decomposition:
- Package lsu_pkg:
  - state enum (IDLE, RD, CAP, WR, RESP)
  - LSU_LAST_ADDR = 16'hFFFF
  - byte lane width 8
- One combinational sub-module, lsu_byte_lane: byte extract with sign/zero extension, and byte-store merge. The FSM stays in load_store_unit.

Test Plan:
1. Memory in its reset image (mem[0]=CD, mem[1]=2B). Word load addr 0 -> resp_rdata=16'h2BCD, resp_err=0, resp_valid 3 cycles after accept.
2. Byte load addr 0, req_signed=1 -> 16'hFFCD. Byte load addr 0, req_signed=0 -> 16'h00CD. Byte load addr 1, signed -> 16'h002B.
3. Byte store 8'h5A to addr 0, then word load addr 0 -> 16'h2B5A. Exactly one mem_re pulse then one mem_we pulse; resp_valid 4 cycles after accept.
4. Word store 16'hBEEF to addr 0x0010, hold resp_ready=0 for 5 cycles -> resp_valid and outputs held stable, req_ready=0. Word load 0x0010 -> 16'hBEEF.
5. Word load at 0xFFFF -> resp_err=1 after 1 cycle, no mem_re/mem_we. With LSU_ALIGN_CHECK_EN, word store at 0x0003 -> resp_err=1 and memory unchanged; without the macro it succeeds.
6. Assert reset during the CAP state of a byte store -> next cycle IDLE, no mem_we ever issued, memory word unchanged, req_ready=1.
